// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
// Imported by the arbiter, its interface and the rr_pick helper.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BEATS = 16;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Producer-side handshake bundle plus the FIFO write port.
// master = producers/FIFO environment, slave = arbiter.
interface fifo_wr_arb_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);

    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [WIDTH-1:0]     req_data [NREQ];
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 fifo_full;
    logic                 fifo_wr_en;
    logic [IDW+WIDTH-1:0] fifo_din;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_din
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_din
    );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin select starting after last_grant.
// Shared with the read-side schedulers.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    localparam int IDW = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(last_grant) + i) % NREQ);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Grant is held for a whole packet: until last or MAX_BEATS beats.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BEATS = DEF_MAX_BEATS,
    localparam int IDW      = id_w(NREQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_wr_arb_if.slave   bus,
    output logic [IDW-1:0] grant_id,
    output logic           busy,
    output logic           err_timeout
);

    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW:0] MAXB = (CW + 1)'(MAX_BEATS);

    state_t         state_q, state_d;
    logic [IDW-1:0] gid_q;
    logic [IDW-1:0] last_q;
    logic [CW-1:0]  cnt_q;
    logic           err_q;

    logic [IDW-1:0] win;
    logic           any;
    logic           fire;
    logic           hit;
    logic           rel;
    logic [CW:0]    nxt;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_q),
        .winner     (win),
        .any        (any)
    );

    assign busy = (state_q == GRANT);
    assign fire = busy & bus.req_valid[gid_q] & ~bus.fifo_full;
    assign nxt  = {1'b0, cnt_q} + 1'b1;
    assign hit  = (nxt == MAXB);
    assign rel  = fire & (bus.req_last[gid_q] | hit);

    // Outputs depend only on registered grant plus valid/full.
    assign bus.fifo_wr_en = fire;
    assign bus.req_ready  = fire ? (NREQ'(1) << gid_q) : '0;
    assign bus.fifo_din   = {gid_q, bus.req_data[gid_q]};
    assign grant_id       = gid_q;
    assign err_timeout    = err_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any) state_d = GRANT;
            GRANT:   if (rel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gid_q   <= '0;
            last_q  <= IDW'(NREQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= fire & hit & ~bus.req_last[gid_q];
            if (state_q == IDLE && any) begin
                gid_q <= win;
                cnt_q <= '0;
            end
            if (fire) cnt_q <= nxt[CW-1:0];
            if (rel) last_q <= gid_q;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed packet scenarios plus random traffic
// against a packet-level arbitration model.
module tb_fifo_wr_arb;
    import fifo_arb_pkg::*;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MB  = 4;
    localparam int IDW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arb_if #(.NREQ(N), .WIDTH(W)) bus ();
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           err_timeout;

    fifo_wr_arb #(.NREQ(N), .WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    int total = 0;
    int bad = 0;

    // Model: owner of the write port (-1 = none), rotation pointer.
    int   owner, lastg, gidm, beats;
    bit   errm;
    logic [N-1:0] last_rdy;
    int   errcnt;
    int   wr_ids[$];
    logic [W-1:0] wr_data[$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        lastg = N - 1;
        gidm = 0;
        beats = 0;
        errm = 0;
        last_rdy = '0;
    endtask

    task automatic step();
        logic [N-1:0] er;
        logic ew;
        logic [IDW+W-1:0] ed;
        int r;
        #1;
        er = '0;
        ew = 1'b0;
        ed = '0;
        if (owner >= 0 && bus.req_valid[owner] && !bus.fifo_full) begin
            ew = 1'b1;
            er[owner] = 1'b1;
            ed = {IDW'(owner), bus.req_data[owner]};
        end
        chk("wr_en", 64'(bus.fifo_wr_en), 64'(ew));
        chk("ready", 64'(bus.req_ready), 64'(er));
        if (ew) begin
            chk("din", 64'(bus.fifo_din), 64'(ed));
            wr_ids.push_back(owner);
            wr_data.push_back(bus.req_data[owner]);
        end
        chk("grant_id", 64'(grant_id), 64'(gidm));
        chk("busy", 64'(busy), 64'(owner >= 0));
        chk("err", 64'(err_timeout), 64'(errm));
        if (err_timeout === 1'b1) errcnt++;
        last_rdy = er;
        errm = 0;
        if (owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                r = (lastg + i) % N;
                if (owner < 0 && bus.req_valid[r]) begin
                    owner = r;
                    gidm = r;
                    beats = 0;
                end
            end
        end else if (ew) begin
            beats++;
            if (bus.req_last[owner]) begin
                lastg = owner;
                owner = -1;
            end else if (beats == MB) begin
                lastg = owner;
                owner = -1;
                errm = 1;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic send(int r, logic [W-1:0] d, logic l);
        int n;
        bus.req_valid[r] = 1'b1;
        bus.req_data[r] = d;
        bus.req_last[r] = l;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_rdy[r] && n < 12);
        chk("send_accept", 64'(last_rdy[r]), 64'd1);
    endtask

    task automatic rand_drive();
        for (int r = 0; r < N; r++) begin
            if (!(bus.req_valid[r] && !last_rdy[r])) begin
                bus.req_valid[r] = ($urandom_range(0, 3) != 0);
                bus.req_data[r] = W'($urandom);
                bus.req_last[r] = ($urandom_range(0, 2) == 0);
            end
        end
        bus.fifo_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic chk_ids(string tag, int id, int first, int cnt);
        for (int k = first; k < first + cnt; k++)
            chk(tag, 64'(wr_ids[k]), 64'(id));
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last = '0;
        bus.fifo_full = 1'b0;
        for (int r = 0; r < N; r++) bus.req_data[r] = '0;
        model_reset();
        errcnt = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);
        rst_n = 1'b1;

        // Round robin of single-beat packets, one bubble each.
        bus.req_valid = '1;
        bus.req_last = '1;
        for (int r = 0; r < N; r++) bus.req_data[r] = W'(8'h10 + r);
        repeat (12) step();
        chk("rr_count", 64'(wr_ids.size()), 64'd6);
        for (int k = 0; k < 6; k++)
            chk("rr_order", 64'(wr_ids[k]), 64'(k % N));

        // Req 2 three-beat packet while req 0 waits.
        wr_ids.delete();
        wr_data.delete();
        bus.req_valid = 4'b0101;
        bus.req_data[0] = 8'h50;
        send(2, 8'hA1, 1'b0);
        send(2, 8'hA2, 1'b0);
        send(2, 8'hA3, 1'b1);
        bus.req_valid[2] = 1'b0;
        repeat (2) step();
        bus.req_valid = '0;
        repeat (2) step();
        chk("pkt_count", 64'(wr_ids.size()), 64'd4);
        chk_ids("pkt_id", 2, 0, 3);
        chk("pkt_d0", 64'(wr_data[0]), 64'h A1);
        chk("pkt_d1", 64'(wr_data[1]), 64'h A2);
        chk("pkt_d2", 64'(wr_data[2]), 64'h A3);
        chk("pkt_next", 64'(wr_ids[3]), 64'd0);

        // Req 3 packet: full stall, then valid gap, under contention.
        wr_ids.delete();
        wr_data.delete();
        send(3, 8'hB0, 1'b0);
        bus.req_valid = 4'b1111;
        bus.req_last = 4'b0111;
        bus.req_data[3] = 8'hB1;
        bus.fifo_full = 1'b1;
        repeat (5) step();
        bus.fifo_full = 1'b0;
        step();
        chk("full_resume", 64'(last_rdy[3]), 64'd1);
        bus.req_valid[3] = 1'b0;
        repeat (3) step();
        send(3, 8'hB2, 1'b1);
        bus.req_valid = '0;
        repeat (2) step();
        chk("stall_count", 64'(wr_ids.size()), 64'd3);
        chk_ids("stall_id", 3, 0, 3);
        chk("stall_d0", 64'(wr_data[0]), 64'h B0);
        chk("stall_d1", 64'(wr_data[1]), 64'h B1);
        chk("stall_d2", 64'(wr_data[2]), 64'h B2);

        // Req 1 streams past the beat limit.
        wr_ids.delete();
        wr_data.delete();
        errcnt = 0;
        for (int k = 0; k < 6; k++) send(1, W'(8'hC0 + k), 1'b0);
        send(1, 8'hC6, 1'b1);
        bus.req_valid = '0;
        repeat (2) step();
        chk("to_count", 64'(wr_ids.size()), 64'd7);
        chk("to_pulses", 64'(errcnt), 64'd1);
        chk_ids("to_id", 1, 0, 7);
        for (int k = 0; k < 7; k++)
            chk("to_data", 64'(wr_data[k]), 64'(8'hC0 + k));

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            rand_drive();
            step();
        end

        // Asynchronous reset in the middle of a packet.
        for (int c = 0; c < 50 && owner < 0; c++) begin
            rand_drive();
            step();
        end
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        chk("arst_ready", 64'(bus.req_ready), 64'd0);
        chk("arst_grant", 64'(grant_id), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_err", 64'(err_timeout), 64'd0);
        model_reset();
        @(negedge clk);
        #1;
        bus.req_valid = '1;
        bus.req_last = '1;
        bus.fifo_full = 1'b0;
        rst_n = 1'b1;
        wr_ids.delete();
        wr_data.delete();
        repeat (4) step();
        chk("post_rst_n", 64'(wr_ids.size()), 64'd2);
        chk("post_rst_first", 64'(wr_ids[0]), 64'd0);
        chk("post_rst_second", 64'(wr_ids[1]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-side arbiter that shares one `fifo` write port among NREQ producers using valid/ready handshakes. It grants one producer at a time and holds the grant for a whole packet, ending at `last` or at a beat limit. Each beat is written as {source id, data}, so the consumer on the FIFO read side knows the origin of every entry. It sits between the producer blocks and `fifo.wr_en`/`din`/`full`.

## Interface
- NREQ, 4, number of requesters (≥2)
- WIDTH, 8, payload width per beat
- MAX_BEATS, 16, beat limit per grant (≥1)
- IDW, $clog2(NREQ), derived id width, not overridable
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ×WIDTH  per-requester payload, unpacked array [NREQ]
- req_last  in  NREQ  final beat of packet
- req_ready  out  NREQ  beat accepted this cycle when valid&ready
- fifo_full  in  1  from fifo.full
- fifo_wr_en  out  1  to fifo.wr_en
- fifo_din  out  IDW+WIDTH  {grant_id, data} to fifo.din (FIFO instantiated with WIDTH=IDW+WIDTH)
- grant_id  out  IDW  currently/last granted requester
- busy  out  1  high in GRANT state
- err_timeout  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, GRANT.
- IDLE: if any req_valid, pick winner by round-robin starting at (last_grant+1) mod NREQ; register grant_id, clear beat count, go GRANT. No transfer in IDLE.
- GRANT: req_ready[grant_id] = req_valid[grant_id] & !fifo_full; all other ready bits 0. fifo_wr_en = same term. fifo_din = {grant_id, req_data[grant_id]}.
- Transfer (fire) = fifo_wr_en. On each fire the beat count increments.
- Release on fire with req_last → IDLE, last_grant := grant_id.
- Release on fire with beat count reaching MAX_BEATS without last → IDLE, last_grant := grant_id, err_timeout pulses the next cycle.
- The granted requester dropping valid mid-packet does not release the grant. The arbiter waits indefinitely with a packet lock.
- fifo_full high: no fire, state and count held. Writes never occur while full.
- Non-granted valids are ignored until the next IDLE, and producers must hold data stable while valid&!ready.
- Beat counter width: $clog2(MAX_BEATS+1), never wraps.

## Timing
- Reset values: state IDLE, fifo_wr_en 0, req_ready 0, grant_id 0, busy 0, err_timeout 0, last_grant NREQ-1, so requester 0 has first priority.
- Grant latency: valid seen in IDLE at cycle N, first possible fire at N+1.
- One mandatory IDLE bubble between packets. Sustained throughput is L/(L+1) beats/cycle for L-beat packets.
- fifo_wr_en, req_ready and fifo_din are combinational from registered state/grant_id plus req_valid/fifo_full. There are no input-to-output paths through arbitration logic.
- Single-beat packet with last=1 on the first fire: GRANT lasts 1 cycle.
- Full deasserting: fire occurs the same cycle fifo_full is low.
- Reset mid-packet: immediate return to reset values, and the partial packet in the FIFO is the system's responsibility.
- The FIFO drains independently, and rd_en has no interaction with this block.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, GRANT), function for id width, default parameter constants.
- Sub-module rr_pick: combinational round-robin priority select (inputs req vector and last_grant, outputs winner index and any). This is the natural single sub-module, reused by read-side schedulers.
- Top holds FSM, grant/last_grant/beat count registers, and output muxing.

## Test plan
- Reset then req_valid=4'b1111, all 1-beat last packets, FIFO never full → fifo_din ids written in order 0,1,2,3,0…, with one idle cycle between writes.
- Req 2 sends 3-beat packet 0xA1,0xA2,0xA3(last) while req 0 is valid → FIFO gets {2,A1},{2,A2},{2,A3} then {0,…}. req_ready[0]=0 throughout.
- fifo_full forced high for 5 cycles mid-packet → fifo_wr_en=0, grant_id and count unchanged, and the packet resumes with no lost or duplicated beat.
- MAX_BEATS=4, req 1 streams 6 beats without last → 4 beats written, err_timeout pulses once, re-arbitration occurs, and the remaining beats go after the next grant to req 1.
- Granted req 3 drops valid for 3 cycles mid-packet while others are valid → no writes, grant stays 3, and the packet completes after valid returns.
- rst_n asserted mid-packet → all outputs return to reset values asynchronously, and the first grant after reset goes to requester 0.
